// File: rtl/stream_framer.sv
// Frames a raw valid/sync pixel stream into the pipeline's fixed-point stream with
// row/frame markers; one-cycle latency, no backpressure.
module stream_framer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FRAC_BITS    = 13,
    parameter int unsigned DATA_O_WIDTH = 22,
    parameter int unsigned IMG_WIDTH    = 320,
    parameter int unsigned IMG_HEIGHT   = 240
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    valid_i,
    input  logic                    sync_i,
    output logic [DATA_O_WIDTH-1:0] data_o,
    output logic                    data_valid_o,
    output logic                    sop_o,
    output logic                    eop_o,
    output logic                    sof_o,
    output logic                    eof_o,
    output logic                    frame_err_o
);

    localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

    if (DATA_O_WIDTH < DATA_WIDTH + FRAC_BITS + 1) begin : gen_width_check
        $error("stream_framer: DATA_O_WIDTH too small for DATA_WIDTH+FRAC_BITS+1");
    end
    if (IMG_WIDTH < 1 || IMG_HEIGHT < 1) begin : gen_size_check
        $error("stream_framer: image dimensions must be >= 1");
    end

    typedef enum logic {StIdle, StActive} state_e;

    state_e                  state_q, state_d;
    logic [ColW-1:0]         col_q, col_d, col_cur;
    logic [RowW-1:0]         row_q, row_d, row_cur;
    logic [DATA_O_WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    sop_q, sop_d, eop_q, eop_d;
    logic                    sof_q, sof_d, eof_q, eof_d;
    logic                    err_q, err_d;
    logic                    start, accept, last_col, last_row;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        err_d   = 1'b0;

        // A sync beat always counts as pixel (0,0), whatever state we are in.
        start    = valid_i && sync_i;
        accept   = valid_i && (sync_i || (state_q == StActive));
        col_cur  = start ? '0 : col_q;
        row_cur  = start ? '0 : row_q;
        last_col = (col_cur == ColLast);
        last_row = (row_cur == RowLast);

        if (accept) begin
            valid_d = 1'b1;
            data_d  = DATA_O_WIDTH'({data_i, {FRAC_BITS{1'b0}}});
            sop_d   = (col_cur == '0);
            eop_d   = last_col;
            sof_d   = (col_cur == '0) && (row_cur == '0);
            eof_d   = last_col && last_row;
            err_d   = start && (state_q == StActive);
            if (last_col && last_row) begin
                col_d   = '0;
                row_d   = '0;
                state_d = StIdle;
            end else if (last_col) begin
                col_d   = '0;
                row_d   = row_cur + 1'b1;
                state_d = StActive;
            end else begin
                col_d   = col_cur + 1'b1;
                row_d   = row_cur;
                state_d = StActive;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            err_q   <= err_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign sop_o        = sop_q;
    assign eop_o        = eop_q;
    assign sof_o        = sof_q;
    assign eof_o        = eof_q;
    assign frame_err_o  = err_q;

endmodule

// File: tb/tb_stream_framer.sv
// Directed bench for stream_framer: a 4x2 instance for the main sequences and a
// 1x1 instance for the degenerate frame size.
module tb_stream_framer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  data_i = '0;
    logic        valid_i = 1'b0;
    logic        sync_i = 1'b0;

    logic [21:0] data_o, data1_o;
    logic        dv_o, sop_o, eop_o, sof_o, eof_o, err_o;
    logic        dv1_o, sop1_o, eop1_o, sof1_o, eof1_o, err1_o;

    int compared = 0;
    int mismatched = 0;
    logic [21:0] exp_data = '0;

    always #5 clk = ~clk;

    stream_framer #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .data_i(data_i), .valid_i(valid_i), .sync_i(sync_i),
        .data_o(data_o), .data_valid_o(dv_o), .sop_o(sop_o), .eop_o(eop_o), .sof_o(sof_o),
        .eof_o(eof_o), .frame_err_o(err_o)
    );

    stream_framer #(.IMG_WIDTH(1), .IMG_HEIGHT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .data_i(data_i), .valid_i(valid_i), .sync_i(sync_i),
        .data_o(data1_o), .data_valid_o(dv1_o), .sop_o(sop1_o), .eop_o(eop1_o), .sof_o(sof1_o),
        .eof_o(eof1_o), .frame_err_o(err1_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {err, sof, eof, sop, eop}.
    task automatic beat(input string tag, input logic v, input logic s, input logic [7:0] d,
                        input logic exp_v, input logic [4:0] exp_f);
        valid_i = v;
        sync_i  = s;
        data_i  = d;
        @(posedge clk);
        #1;
        if (exp_v) exp_data = {6'd0, d, 13'd0};
        chk({tag, ".valid"}, 32'(dv_o), 32'(exp_v));
        chk({tag, ".flags"}, 32'({err_o, sof_o, eof_o, sop_o, eop_o}), 32'(exp_f));
        chk({tag, ".data"}, 32'(data_o), 32'(exp_data));
        valid_i = 1'b0;
        sync_i  = 1'b0;
    endtask

    function automatic logic [4:0] fl(input int i, input logic err);
        return {err, i == 0, i == 7, (i % 4) == 0, (i % 4) == 3};
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(dv_o), 0);
        chk("rst.data", 32'(data_o), 0);
        chk("rst.flags", 32'({err_o, sof_o, eof_o, sop_o, eop_o}), 0);
        #2 reset_n = 1'b1;

        // Contiguous 4x2 frame, data 0..7
        for (int i = 0; i < 8; i++) beat($sformatf("f1.b%0d", i), 1'b1, i == 0, 8'(i), 1'b1, fl(i, 1'b0));
        chk("f1.d7", 32'(data_o), 32'd57344);

        // Full-scale pixel, sign bit stays 0
        for (int i = 0; i < 8; i++) beat($sformatf("f2.b%0d", i), 1'b1, i == 0, 8'd255, 1'b1, fl(i, 1'b0));
        chk("f2.max", 32'(data_o), 32'h1FE000);
        chk("f2.msb", 32'(data_o[21]), 0);

        // Unsynced beats in idle are dropped and data_o holds
        beat("idle.a", 1'b1, 1'b0, 8'd9, 1'b0, 5'b0);
        beat("idle.b", 1'b1, 1'b0, 8'd10, 1'b0, 5'b0);

        // Frame with valid gaps
        for (int i = 0; i < 8; i++) begin
            if (i == 1 || i == 2 || i == 5) begin
                beat($sformatf("gap.g%0d", i), 1'b0, 1'b0, 8'hAA, 1'b0, 5'b0);
                beat($sformatf("gap.h%0d", i), 1'b0, 1'b1, 8'hAB, 1'b0, 5'b0);
            end
            beat($sformatf("gap.b%0d", i), 1'b1, i == 0, 8'(20 + i), 1'b1, fl(i, 1'b0));
        end

        // Early restart on beat 5, then the restarted frame completes
        for (int i = 0; i < 5; i++) beat($sformatf("er.b%0d", i), 1'b1, i == 0, 8'(40 + i), 1'b1, fl(i, 1'b0));
        beat("er.restart", 1'b1, 1'b1, 8'd50, 1'b1, 5'b11010);
        for (int i = 1; i < 8; i++) beat($sformatf("er.n%0d", i), 1'b1, 1'b0, 8'(50 + i), 1'b1, fl(i, 1'b0));
        beat("er.after", 1'b1, 1'b0, 8'd77, 1'b0, 5'b0);

        // Asynchronous reset mid-frame
        beat("ar.b0", 1'b1, 1'b1, 8'd3, 1'b1, fl(0, 1'b0));
        beat("ar.b1", 1'b1, 1'b0, 8'd4, 1'b1, fl(1, 1'b0));
        #2 reset_n = 1'b0;
        #1;
        chk("ar.valid", 32'(dv_o), 0);
        chk("ar.data", 32'(data_o), 0);
        chk("ar.flags", 32'({err_o, sof_o, eof_o, sop_o, eop_o}), 0);
        #10 reset_n = 1'b1;
        exp_data = '0;
        beat("ar.drop", 1'b1, 1'b0, 8'd5, 1'b0, 5'b0);
        beat("ar.sync", 1'b1, 1'b1, 8'd6, 1'b1, fl(0, 1'b0));

        // 1x1 frames: every synced beat carries all four markers, no error
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            sync_i  = (i != 2);
            data_i  = 8'(i + 1);
            @(posedge clk);
            #1;
            chk($sformatf("one.valid%0d", i), 32'(dv1_o), 32'(i != 2));
            chk($sformatf("one.flags%0d", i), 32'({err1_o, sof1_o, eof1_o, sop1_o, eop1_o}),
                (i != 2) ? 32'b01111 : 32'b0);
            if (i != 2) chk($sformatf("one.data%0d", i), 32'(data1_o), 32'((i + 1) << 13));
        end
        valid_i = 1'b0;
        sync_i  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stream_framer.md
Name: stream_framer

Overview:
- Front-end source for the convolution pipeline.
- Takes a raw 8-bit unsigned pixel stream carrying only a valid strobe and a frame-sync pulse.
- Produces the pipeline's framed stream: signed fixed-point data with FRAC_BITS fractional bits, plus valid, sop, eop, sof and eof.
- Is the inverse end of the saturating output stage. That stage drops FRAC_BITS and clamps to 0..MAX_DATA; this block re-expands pixels into the fixed-point domain and generates the framing that stage consumes.

Parameters:
- DATA_WIDTH, 8, input pixel width (unsigned).
- FRAC_BITS, 13, fractional bits added on output (left shift).
- DATA_O_WIDTH, 22, output width (signed). Must be >= DATA_WIDTH+FRAC_BITS+1; elaboration error otherwise.
- IMG_WIDTH, 320, pixels per row (>=1).
- IMG_HEIGHT, 240, rows per frame (>=1).

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- data_i, input, DATA_WIDTH, unsigned pixel.
- valid_i, input, 1, pixel qualifier.
- sync_i, input, 1, frame start. Meaningful only when valid_i=1; marks that pixel as frame pixel 0.
- data_o, output, DATA_O_WIDTH, signed. Zero-extended data_i shifted left by FRAC_BITS.
- data_valid_o, output, 1, output qualifier.
- sop_o, output, 1, first pixel of row.
- eop_o, output, 1, last pixel of row.
- sof_o, output, 1, first pixel of frame.
- eof_o, output, 1, last pixel of frame.
- frame_err_o, output, 1, one-cycle pulse on framing error.

Behaviour:
- Reset (async assert, sync release): all outputs 0, including data_o. State=IDLE, col=0, row=0.
- Latency: fixed 1 cycle, input beat to output beat. No backpressure; every accepted beat emits exactly one output beat.
- data_o = {zeros, data_i, FRAC_BITS zeros}. Sign bit is always 0. Registered only on accepted beats; holds its value otherwise.
- sop_o, eop_o, sof_o, eof_o are never high while data_valid_o=0.
- Counters: col in 0..IMG_WIDTH-1, row in 0..IMG_HEIGHT-1.

State machine:
- IDLE:
  - valid_i=1 with sync_i=0: beat dropped, data_valid_o=0, no error.
  - valid_i=1 with sync_i=1: beat accepted as col=0,row=0. sop_o=sof_o=1. Go to ACTIVE.
- ACTIVE:
  - Each valid_i=1 with sync_i=0 is accepted.
  - sop_o=(col==0). eop_o=(col==IMG_WIDTH-1).
  - sof_o=(col==0 && row==0). eof_o=(col==IMG_WIDTH-1 && row==IMG_HEIGHT-1).
  - After eop, col wraps to 0 and row increments.
  - After eof, counters clear and state returns to IDLE.
- ACTIVE, valid_i=1 with sync_i=1 before eof (early restart):
  - frame_err_o pulses with the output beat.
  - Counters restart; this beat is emitted as col=0,row=0 with sop_o=sof_o=1.
  - State stays ACTIVE.
  - The aborted frame receives no eof.
- Beats with valid_i=0 do not advance counters. Gaps of any length are allowed mid-frame.
- Degenerate sizes:
  - IMG_WIDTH=1: sop_o and eop_o assert on the same beat.
  - IMG_WIDTH=IMG_HEIGHT=1: sop, eop, sof and eof all assert on one beat; state returns to IDLE.
- Sync arriving on the same beat eof would be due (i.e. in IDLE after eof): normal frame start, no error.
- Reset mid-frame: outputs clear immediately. The next frame needs a new sync_i.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, sync_i with first of 8 contiguous beats, data_i=0..7 -> data_o=0,8192,...,57344 one cycle later. sop on beats 0,4; eop on beats 3,7; sof on beat 0; eof on beat 7; frame_err_o=0.
- Same config, data_i=255 -> data_o=2088960 (0x1FE000), data_o MSB=0.
- valid_i beats before any sync_i -> no data_valid_o. Then sync -> first output has sof_o=1.
- Random valid_i gaps inside the 8-beat frame -> identical flag pattern on valid beats only; no flags on idle cycles.
- sync_i on beat 5 of a frame -> frame_err_o pulse on that output beat, which carries sof_o=sop_o=1. A following 8-beat frame ends with eof_o on its beat 7.
- reset_n low for 1 cycle mid-frame (async, between clock edges) -> all outputs 0 immediately. Post-reset beats without sync are dropped.
- IMG_WIDTH=1, IMG_HEIGHT=1 -> every synced beat carries sop, eop, sof and eof together.
